// File: rtl/modn_sched_pkg.sv
// Shared definitions for the modn_sched block: FSM state type, the smallest
// modulus the counter can run with, and helpers that clamp the requested
// modulus and loop count into their legal ranges.
package modn_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // A mod-1 counter would never leave 0, so wrap detection needs at least 2 states.
  localparam int unsigned MIN_MOD = 2;

  function automatic int unsigned clamp_mod(input int unsigned m);
    return (m < MIN_MOD) ? MIN_MOD : m;
  endfunction

  // A run always lasts at least one full wrap.
  function automatic int unsigned clamp_loops(input int unsigned l);
    return (l == 0) ? 1 : l;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. Searches the request vector starting at
// ptr_i and wrapping around; the first set request wins.
//   req_i   : request levels
//   ptr_i   : index where the search starts (highest priority this round)
//   en_i    : arbitration enable; when low no winner is reported
//   gnt_o   : one-hot winner
//   idx_o   : binary index of the winner
//   valid_o : a winner exists
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PTRW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PTRW-1:0] ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PTRW-1:0] idx_o,
  output logic            valid_o
);

  int   cand;
  logic found;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    found   = 1'b0;
    cand    = 0;
    if (en_i) begin
      for (int i = 0; i < NREQ; i++) begin
        cand = (int'(ptr_i) + i) % NREQ;
        if (!found && req_i[cand]) begin
          found       = 1'b1;
          gnt_o[cand] = 1'b1;
          idx_o       = PTRW'(cand);
        end
      end
      valid_o = found;
    end
  end

endmodule

// File: rtl/modn_sched.sv
// Time-shares one programmable mod-M counter among NREQ requesters.
// A round-robin winner's modulus M and loop count L are latched (and clamped);
// the counter then runs for L wraps, pulses done for the winner and releases.
//   clk      : rising-edge clock
//   rst      : asynchronous active-low reset
//   req      : per-requester request levels
//   mod_in   : modulus for requester i at [i*WIDTH +: WIDTH]
//   loops_in : wrap count for requester i at [i*LOOPW +: LOOPW]
//   abort    : terminates the current run without a done pulse
//   gnt      : one-hot grant, held for the run plus the done cycle
//   busy     : resource owned (FSM not idle)
//   cnt_q    : shared counter value
//   wrap     : high while the counter sits at M-1
//   done     : one-cycle completion pulse for the granted requester
module modn_sched
  import modn_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int LOOPW = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*WIDTH-1:0]  mod_in,
  input  logic [NREQ*LOOPW-1:0]  loops_in,
  input  logic                   abort,
  output logic [NREQ-1:0]        gnt,
  output logic                   busy,
  output logic [WIDTH-1:0]       cnt_q,
  output logic                   wrap,
  output logic [NREQ-1:0]        done
);

  localparam int PTRW = $clog2(NREQ);

  state_e            state_q, state_d;
  logic [PTRW-1:0]   ptr_q,   ptr_d;
  logic [WIDTH-1:0]  mod_q,   mod_d;
  logic [LOOPW-1:0]  loops_q, loops_d;
  logic [LOOPW-1:0]  wcnt_q,  wcnt_d;   // wraps completed so far in this run
  logic [WIDTH-1:0]  cnt_d;
  logic [NREQ-1:0]   gnt_q,   gnt_d;
  logic [NREQ-1:0]   done_q,  done_d;

  logic [NREQ-1:0]   arb_gnt;
  logic [PTRW-1:0]   arb_idx;
  logic              arb_valid;
  logic [WIDTH-1:0]  mod_sel;
  logic [LOOPW-1:0]  loops_sel;

  rr_arbiter #(
    .NREQ (NREQ),
    .PTRW (PTRW)
  ) u_arb (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .en_i    (state_q == IDLE),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  assign mod_sel   = mod_in[arb_idx*WIDTH +: WIDTH];
  assign loops_sel = loops_in[arb_idx*LOOPW +: LOOPW];

  assign wrap = (state_q == RUN) && (cnt_q == mod_q - 1'b1);
  assign busy = (state_q != IDLE);
  assign gnt  = gnt_q;
  assign done = done_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    mod_d   = mod_q;
    loops_d = loops_q;
    wcnt_d  = wcnt_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d = RUN;
          gnt_d   = arb_gnt;
          ptr_d   = (arb_idx == PTRW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
          mod_d   = WIDTH'(clamp_mod(32'(mod_sel)));
          loops_d = LOOPW'(clamp_loops(32'(loops_sel)));
          wcnt_d  = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (abort) begin
          // Abort outranks everything, including a coincident final wrap.
          state_d = IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
        end else if (wrap) begin
          cnt_d = '0;
          if (wcnt_q == loops_q - 1'b1) begin
            state_d = DONE;
            done_d  = gnt_q;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        // Unconditional return to IDLE guarantees a one-cycle gap between runs.
        state_d = IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      mod_q   <= WIDTH'(MIN_MOD);
      loops_q <= LOOPW'(1);
      wcnt_q  <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
    end else begin
      // NOTE: registers update with non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      mod_q   <= mod_d;
      loops_q <= loops_d;
      wcnt_q  <= wcnt_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_modn_sched.sv
// Self-checking bench for modn_sched: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// transaction-level model (owner, modulus, loops, elapsed cycles).
module tb_modn_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int LOOPW = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] mod_in = '0;
  logic [NREQ*LOOPW-1:0] loops_in = '0;
  logic                  abort = 1'b0;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic [WIDTH-1:0]      cnt_q;
  logic                  wrap;
  logic [NREQ-1:0]       done;

  always #5 clk = ~clk;

  modn_sched #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH),
    .LOOPW (LOOPW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .mod_in   (mod_in),
    .loops_in (loops_in),
    .abort    (abort),
    .gnt      (gnt),
    .busy     (busy),
    .cnt_q    (cnt_q),
    .wrap     (wrap),
    .done     (done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A run is described by its owner, clamped M and L, and k = cycles elapsed
  // since the grant. k in [0, M*L) is counting, k == M*L is the done cycle.
  bit m_active;
  int m_owner, m_m, m_l, m_k, m_ptr;

  task automatic model_edge();
    if (!m_active) begin
      for (int i = 0; i < NREQ; i++) begin
        int c;
        c = (m_ptr + i) % NREQ;
        if (!m_active && req[c]) begin
          m_active = 1'b1;
          m_owner  = c;
          m_m      = int'(mod_in[c*WIDTH +: WIDTH]);
          m_l      = int'(loops_in[c*LOOPW +: LOOPW]);
          if (m_m < 2) m_m = 2;
          if (m_l == 0) m_l = 1;
          m_k      = 0;
          m_ptr    = (c + 1) % NREQ;
        end
      end
    end else if (abort) begin
      m_active = 1'b0;
    end else if (m_k == m_m * m_l) begin
      m_active = 1'b0;
    end else begin
      m_k++;
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active = 1'b0;
      m_ptr    = 0;
      m_k      = 0;
      m_owner  = 0;
      m_m      = 2;
      m_l      = 1;
    end else begin
      model_edge();
    end
  end

  // Compare process: outputs are checked at every falling edge out of reset.
  always @(negedge clk) begin
    if (rst) begin
      check("gnt",   gnt,   m_active ? (1 << m_owner) : 0);
      check("busy",  busy,  m_active);
      check("cnt_q", cnt_q, (m_active && m_k < m_m * m_l) ? (m_k % m_m) : 0);
      check("wrap",  wrap,  m_active && m_k < m_m * m_l && (m_k % m_m) == m_m - 1);
      check("done",  done,  (m_active && m_k == m_m * m_l) ? (1 << m_owner) : 0);
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(negedge clk);
  endtask

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    int r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic do_reset();
    req      = '0;
    abort    = 1'b0;
    mod_in   = '0;
    loops_in = '0;
    rst      = 1'b0;
    step();
    step();
    check("reset_gnt",  gnt,   0);
    check("reset_busy", busy,  0);
    check("reset_cnt",  cnt_q, 0);
    check("reset_wrap", wrap,  0);
    check("reset_done", done,  0);
    rst = 1'b1;
  endtask

  // Issue one request from requester idx and follow the run to completion.
  task automatic run_single(input int idx, input int m, input int l,
                            output int first_gnt, output int done_step,
                            output int done_val, output int wraps,
                            output int run_cycles, output logic [31:0] trace,
                            output int maxcnt, output int busy_after);
    logic [WIDTH-1:0] mv;
    logic [LOOPW-1:0] lv;
    mv = m[WIDTH-1:0];
    lv = l[LOOPW-1:0];
    req = '0;
    req[idx] = 1'b1;
    mod_in[idx*WIDTH +: WIDTH]   = mv;
    loops_in[idx*LOOPW +: LOOPW] = lv;
    first_gnt = 0; done_step = -1; done_val = 0; wraps = 0;
    run_cycles = 0; trace = '0; maxcnt = 0;
    for (int s = 1; s <= 5000 && done_step < 0; s++) begin
      step();
      if (s == 1) begin
        first_gnt = int'(gnt);
        req = '0;   // dropping the request must not end the run
      end
      if (done != '0) begin
        done_step = s;
        done_val  = int'(done);
      end else if (busy) begin
        run_cycles++;
        if (wrap) wraps++;
        if (s <= 8) trace = {trace[27:0], cnt_q[3:0]};
        if (int'(cnt_q) > maxcnt) maxcnt = int'(cnt_q);
      end
    end
    step();
    busy_after = int'(busy);
  endtask

  // ---------------- stimulus ----------------
  int fg, ds, dv, wr, rc, mc, ba;
  logic [31:0] tr;

  initial begin
    do_reset();

    // Single requester, M=3 L=2.
    run_single(0, 3, 2, fg, ds, dv, wr, rc, tr, mc, ba);
    check("single_first_gnt", fg, 1);
    check("single_cnt_trace", tr, 32'h0001_2012);
    check("single_wraps",     wr, 2);
    check("single_run_len",   rc, 6);
    check("single_done_step", ds, 7);
    check("single_done_val",  dv, 1);
    check("single_busy_drop", ba, 0);

    // Clamping: M=0/L=0 and M=1 behave as M=2/L=1.
    run_single(1, 0, 0, fg, ds, dv, wr, rc, tr, mc, ba);
    check("clamp00_done_step", ds, 3);
    check("clamp00_trace",     tr, 32'h01);
    check("clamp00_done_val",  dv, 2);
    run_single(2, 1, 1, fg, ds, dv, wr, rc, tr, mc, ba);
    check("clamp11_done_step", ds, 3);
    check("clamp11_wraps",     wr, 1);
    run_single(3, 1, 3, fg, ds, dv, wr, rc, tr, mc, ba);
    check("clamp13_done_step", ds, 7);
    check("clamp13_maxcnt",    mc, 1);

    // Fairness: all requesters, M=2 L=1.
    do_reset();
    begin
      logic [NREQ-1:0] prev;
      logic [19:0]     order;
      int ngr, ghigh, glow, first, fifth;
      mod_in   = {NREQ{8'd2}};
      loops_in = {NREQ{4'd1}};
      req      = '1;
      prev = '0; order = '0; ngr = 0; ghigh = 0; glow = 0; first = -1; fifth = -1;
      for (int s = 1; s <= 19; s++) begin
        step();
        if (gnt != '0) ghigh++; else glow++;
        if (gnt != '0 && prev == '0) begin
          ngr++;
          order = {order[15:0], 4'(onehot_idx(gnt))};
          if (ngr == 1) first = s;
          if (ngr == 5) fifth = s;
        end
        prev = gnt;
      end
      req = '0;
      check("fair_order",  order, 20'h01230);
      check("fair_grants", ngr, 5);
      check("fair_gnt_cycles", ghigh, 15);
      check("fair_gap_cycles", glow, 4);
      check("fair_first", first, 1);
      check("fair_fifth", fifth, 17);
      step();
      step();
    end

    // Abort mid-run at cnt_q == 5.
    do_reset();
    begin
      int at;
      mod_in[0*WIDTH +: WIDTH] = 8'd10;
      loops_in[0*LOOPW +: LOOPW] = 4'd1;
      req = 4'b0011;
      at = -1;
      for (int s = 1; s <= 20 && at < 0; s++) begin
        step();
        if (busy && cnt_q == 8'd5) at = s;
      end
      check("abort_seen_step", at, 6);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort_gnt",  gnt,   0);
      check("abort_busy", busy,  0);
      check("abort_cnt",  cnt_q, 0);
      check("abort_done", done,  0);
      step();
      check("abort_next_gnt", gnt, 4'b0010);
      req = '0;
      for (int s = 0; s < 6; s++) step();
    end

    // Abort coinciding with the final wrap.
    do_reset();
    begin
      int at;
      mod_in[0*WIDTH +: WIDTH] = 8'd3;
      loops_in[0*LOOPW +: LOOPW] = 4'd1;
      req = 4'b0001;
      at = -1;
      for (int s = 1; s <= 10 && at < 0; s++) begin
        step();
        req = '0;
        if (wrap) at = s;
      end
      check("finalwrap_step", at, 3);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("finalwrap_done", done, 0);
      check("finalwrap_busy", busy, 0);
    end

    // Asynchronous reset between clock edges.
    do_reset();
    mod_in[2*WIDTH +: WIDTH] = 8'd5;
    loops_in[2*LOOPW +: LOOPW] = 4'd3;
    req = 4'b0100;
    step();
    step();
    step();
    req = '0;
    check("pre_areset_busy", busy, 1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("areset_gnt",  gnt,   0);
    check("areset_busy", busy,  0);
    check("areset_cnt",  cnt_q, 0);
    check("areset_wrap", wrap,  0);
    check("areset_done", done,  0);
    @(negedge clk);
    rst = 1'b1;
    req = '1;
    mod_in = {NREQ{8'd2}};
    step();
    check("areset_first_winner", gnt, 4'b0001);
    req = '0;
    for (int s = 0; s < 4; s++) step();

    // Maximum run, M=255 L=15.
    do_reset();
    run_single(3, 255, 15, fg, ds, dv, wr, rc, tr, mc, ba);
    check("max_run_cycles", rc, 3825);
    check("max_wraps",      wr, 15);
    check("max_done_step",  ds, 3826);
    check("max_maxcnt",     mc, 254);
    check("max_trace",      tr, 32'h0123_4567);
    check("max_done_val",   dv, 8);

    // Randomized traffic checked by the per-cycle compare process.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      req   = ($urandom_range(0, 3) == 0) ? 4'(0) : 4'($urandom_range(0, 15));
      abort = ($urandom_range(0, 29) == 0);
      for (int i = 0; i < NREQ; i++) begin
        mod_in[i*WIDTH +: WIDTH]   = 8'($urandom_range(0, 6));
        loops_in[i*LOOPW +: LOOPW] = 4'($urandom_range(0, 3));
      end
      step();
    end
    req   = '0;
    abort = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/modn_sched.md
# modn_sched

Controller that time-shares one programmable mod-M counter among `NREQ` requesters. Grants are round-robin. The winner's modulus and loop count are latched, and the counter runs for the requested number of wraps. The block then pulses a per-requester `done` and releases the resource. It sits between client timing blocks and the shared counter datapath.

## Interface
- `NREQ`, 4, number of requesters (≥2)
- `WIDTH`, 8, counter/modulus width
- `LOOPW`, 4, loop-count width
- `clk` in 1, rising-edge clock
- `rst` in 1, asynchronous, active-low reset
- `req` in NREQ, per-requester request level
- `mod_in` in NREQ*WIDTH, modulus M for requester i at bits [i*WIDTH +: WIDTH]
- `loops_in` in NREQ*LOOPW, wrap count L for requester i at bits [i*LOOPW +: LOOPW]
- `abort` in 1, terminates the current run
- `gnt` out NREQ, one-hot grant
- `busy` out 1, resource owned
- `cnt_q` out WIDTH, shared counter value
- `wrap` out 1, single-cycle pulse on the cycle where `cnt_q == M-1`
- `done` out NREQ, single-cycle completion pulse for the granted requester

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE:** if any `req` is set, pick a winner by round-robin, latch its M and L, go to RUN. With no request, stay in IDLE.
- **Round-robin:** search starts at `ptr`. `ptr` becomes (winner+1) mod NREQ at grant time.
- **Modulus clamping:** latched M of 0 or 1 is forced to 2. L=0 is forced to 1. Values are frozen for the whole run; later `mod_in`/`loops_in` changes are ignored.
- **RUN:** `cnt_q` counts 0,1,…,M-1,0,… and the counter has exactly M states. `wrap` is asserted combinationally while `cnt_q == M-1`. An internal wrap counter increments on each wrap. The L-th wrap moves the FSM to DONE.
- **DONE:** `done[winner]=1` for one cycle, `cnt_q=0`, then back to IDLE.
- **Request deassertion:** dropping `req` during RUN does not end the run.
- **Abort:** `abort` in RUN or DONE moves to IDLE on the next edge. `gnt`, `busy` and `cnt_q` clear, and no `done` is issued. `ptr` keeps its advanced value. `abort` in IDLE is ignored.
- **Abort vs. final wrap:** if `abort` coincides with the final wrap, abort wins and there is no `done`.
- **Reset:** state IDLE; `ptr`=0; `gnt`=0, `busy`=0, `cnt_q`=0, `wrap`=0, `done`=0. Reset mid-run clears everything immediately, without waiting for a clock edge.

## Timing
- `req` sampled high in IDLE at edge t gives `gnt`/`busy` high and `cnt_q`=0 from t+1.
- RUN lasts exactly M*L cycles. DONE is 1 cycle. `gnt` is high for M*L+1 cycles.
- `busy` equals (state != IDLE).
- After DONE there is at least one IDLE cycle. The next grant appears at DONE+2, so back-to-back runs have a 1-cycle gap.
- `cnt_q`, `gnt`, `busy` and `done` are registered. `wrap` is decoded from registered state.

## Structure
- Shared package `modn_sched_pkg` holds:
  - state enum (IDLE, RUN, DONE)
  - minimum-modulus constant (2)
  - clamp function for M and L
- Sub-module `rr_arbiter` (NREQ-wide):
  - inputs: `req`, `ptr`, enable
  - outputs: one-hot winner and its index
- Counter, wrap counter and FSM live in `modn_sched`.

## Test plan
- **Single requester:** `req[0]`, M=3, L=2. `gnt[0]` at t+1. `cnt_q` runs 0,1,2,0,1,2. `wrap` pulses twice. `done[0]` pulses at cycle t+7. `busy` drops at t+8.
- **Fairness:** all four `req` held after reset, M=2, L=1. Grant order is 0,1,2,3,0, each grant lasting 3 cycles with a 1-cycle gap.
- **Clamping:** M=0, L=0 behaves identically to M=2, L=1. M=1 also behaves as M=2.
- **Abort mid-run:** M=10, `abort` at `cnt_q`=5. Next cycle `gnt`=0, `busy`=0, `cnt_q`=0, and no `done`. The next grant goes to the following requester.
- **Asynchronous reset:** `rst` pulled low mid-run between clock edges. All outputs are 0 immediately. After release, requester 0 wins first.
- **Maximum run:** M=255, L=15. Exactly 3825 RUN cycles and 15 wraps, with no overflow of `cnt_q` or the loop counter.
